// File: rtl/sr_pkg.sv
// sr_pkg: shared types for the SR pulse sequencer.
//   sr_cmd_e   - command codes carried on the command channel
//   sr_state_e - sequencer FSM states
//   sr_cmd_t   - one queued command {cmd, len}, sized by SR_CNT_W
package sr_pkg;

    // Default pulse-length width; sr_cmd_t is sized by it.
    localparam int SR_CNT_W = 8;

    typedef enum logic [1:0] {
        CMD_HOLD   = 2'b00,
        CMD_RESET  = 2'b01,
        CMD_SET    = 2'b10,
        CMD_TOGGLE = 2'b11
    } sr_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } sr_state_e;

    typedef struct packed {
        sr_cmd_e               cmd;
        logic [SR_CNT_W-1:0]   len;
    } sr_cmd_t;

endpackage

// File: rtl/sr_pulse_sequencer_if.sv
// sr_pulse_sequencer_if: valid/ready command channel into the sequencer.
//   in_valid - command present (master -> slave)
//   in_ready - slave can accept (slave -> master)
//   in_cmd   - command code, see sr_pkg::sr_cmd_e
//   in_len   - pulse length in cycles, 0 behaves as 1
interface sr_pulse_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_cmd;
    logic [CNT_W-1:0] in_len;

    modport master (
        output in_valid,
        output in_cmd,
        output in_len,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_cmd,
        input  in_len,
        output in_ready
    );
endinterface

// File: rtl/sr_cmd_fifo.sv
// sr_cmd_fifo: synchronous command FIFO.
//   clk, rstn - clock, synchronous active-low reset (empties the FIFO)
//   push_i    - write wdata_i (ignored while full)
//   wdata_i   - entry to write
//   pop_i     - discard head entry (ignored while empty)
//   rdata_o   - current head entry
//   full_o    - DEPTH entries stored
//   empty_o   - no entries stored
module sr_cmd_fifo
    import sr_pkg::*;
#(
    parameter type entry_t = sr_cmd_t,
    parameter int  DEPTH   = 4
) (
    input  logic   clk,
    input  logic   rstn,
    input  logic   push_i,
    input  entry_t wdata_i,
    input  logic   pop_i,
    output entry_t rdata_o,
    output logic   full_o,
    output logic   empty_o
);
    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when indices match.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    entry_t      mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

    // The FSM decides on the head in the same cycle it pops it, so the
    // head is presented directly from the storage array.
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/sr_pulse_sequencer.sv
// sr_pulse_sequencer: turns queued SET/RESET/TOGGLE/HOLD commands into
// timed, mutually exclusive s/r pulses for an SR flip-flop, with a forced
// idle gap after every pulse and a shadow of the flop's expected q.
//   clk, rstn - clock, synchronous active-low reset
//   cmd_if    - command channel (valid/ready, cmd, len)
//   s, r      - registered drive to the SR flop, never both high
//   q_shadow  - value the flop holds once it samples the current drive
//   busy      - pulse/gap in progress or commands still queued
module sr_pulse_sequencer
    import sr_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 8,
    parameter int MIN_GAP = 1
) (
    input  logic                       clk,
    input  logic                       rstn,
    sr_pulse_sequencer_if.slave        cmd_if,
    output logic                       s,
    output logic                       r,
    output logic                       q_shadow,
    output logic                       busy
);
    typedef struct packed {
        sr_cmd_e          cmd;
        logic [CNT_W-1:0] len;
    } entry_t;

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] DRIVE = ST_DRIVE;
    localparam logic [1:0] GAP   = ST_GAP;

    // Gap counter reload; unused when MIN_GAP is 0 (DRIVE returns to IDLE).
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s_q, s_d;
    logic             r_q, r_d;
    logic             qs_q, qs_d;

    logic   fifo_full;
    logic   fifo_empty;
    logic   fifo_push;
    logic   launch;
    entry_t wr_entry;
    entry_t head;

    assign wr_entry  = {cmd_if.in_cmd, cmd_if.in_len};
    assign fifo_push = cmd_if.in_valid && !fifo_full;
    assign cmd_if.in_ready = !fifo_full;

    sr_cmd_fifo #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (fifo_push),
        .wdata_i (wr_entry),
        .pop_i   (launch),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        r_d     = r_q;
        qs_d    = qs_q;
        launch  = 1'b0;

        case (state_q)
            IDLE: begin
                launch = !fifo_empty;
            end
            DRIVE: begin
                if (cnt_q == '0) begin
                    s_d = 1'b0;
                    r_d = 1'b0;
                    if (MIN_GAP > 0) begin
                        state_d = GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                // The last gap cycle launches a queued command directly so
                // back-to-back pulses are separated by exactly MIN_GAP cycles.
                if (cnt_q == '0) begin
                    if (!fifo_empty) begin
                        launch = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (launch) begin
            state_d = DRIVE;
            // len 0 behaves as 1; len all-ones loads without overflow.
            cnt_d   = (head.len == '0) ? '0 : head.len - CNT_W'(1);
            case (head.cmd)
                CMD_SET: begin
                    s_d  = 1'b1;
                    r_d  = 1'b0;
                    qs_d = 1'b1;
                end
                CMD_RESET: begin
                    s_d  = 1'b0;
                    r_d  = 1'b1;
                    qs_d = 1'b0;
                end
                CMD_TOGGLE: begin
                    s_d  = !qs_q;
                    r_d  = qs_q;
                    qs_d = !qs_q;
                end
                default: begin
                    s_d = 1'b0;
                    r_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            qs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            r_q     <= r_d;
            qs_q    <= qs_d;
        end
    end

    assign s        = s_q;
    assign r        = r_q;
    assign q_shadow = qs_q;
    assign busy     = (state_q != IDLE) || !fifo_empty;

endmodule
